freq_display: RTL
=================

Name: freq_display

Overview:
- Downstream stage of the frequency counter. Consumes the binary frequency word plus a one-cycle LOAD strobe issued each time the counter's measurement window closes.
- Converts the word to BCD sequentially (shift-and-add-3 FSM), then time-multiplexes the result onto a 4-digit common-anode 7-segment display.
- Provides leading-zero blanking and an overflow indication. Runs on the 100 MHz board clock.

Parameters:
- IN_W, 16, width of the binary input VALUE (must be >= 4).
- DIGITS, 4, number of physical display digits.
- REFRESH_DIV, 100000, CLK cycles each digit stays lit (1 ms at 100 MHz). Sim uses 4.

Ports:
- CLK  input  1  system clock, 100 MHz, rising edge.
- RESET  input  1  synchronous, active-low reset (sampled on CLK rising edge).
- VALUE  input  IN_W  binary frequency to display, unsigned.
- LOAD  input  1  one-cycle strobe; VALUE is captured when LOAD=1 and BUSY=0.
- BUSY  output  1  high while a conversion is in progress.
- SEG  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
- AN  output  DIGITS  digit enables, active-low, one-hot; AN[0] is the rightmost (units) digit.

Behaviour:
- Reset (RESET=0 at an edge):
  - FSM goes to IDLE; BUSY=0.
  - Display BCD register cleared to 0; overflow flag cleared.
  - Refresh counter and digit index reset to 0, so AN=1110 and SEG=1000000 (shows "0").
  - Reset mid-conversion aborts the conversion and discards any partial result.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: on LOAD=1, capture VALUE into the shift register, clear the scratch BCD, set iteration counter = IN_W, go to SHIFT.
  - SHIFT: each cycle, add 3 to every scratch nibble that is >= 5, then shift {scratch, shiftreg} left by 1 (both in one cycle). Decrement the counter. Go to DONE after IN_W cycles.
  - DONE: copy the low DIGITS nibbles of scratch to the display register. Set overflow = 1 if any scratch nibble above DIGITS-1 is nonzero (i.e. VALUE > 10^DIGITS - 1), else 0. Return to IDLE.
- Scratch width is 4*ceil(IN_W/3) bits, which is sufficient for any IN_W.
- Timing: BUSY=1 for exactly IN_W+1 cycles, starting the cycle after the accepting LOAD edge. The display register updates on the edge that drops BUSY. Latency from LOAD to new display = IN_W+2 edges.
- LOAD while BUSY=1 is ignored, with no queueing. This includes LOAD asserted in the DONE cycle.
- The display register holds the previous value throughout a conversion, so there is no partial or flickering output.
- Multiplexing runs independently of the conversion FSM:
  - Refresh counter counts 0..REFRESH_DIV-1.
  - On wrap, digit index increments mod DIGITS; AN = ~(1 << index).
- Digit content:
  - Overflow=1: every digit shows a dash, SEG=0111111.
  - Otherwise, digit k>0 is blank (SEG=1111111) when display digits k..DIGITS-1 are all zero. Digit 0 always shows its value.
- Decode patterns {gfedcba}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Nibbles 10-15 cannot occur; decode them as blank.
- SEG and AN are registered. A change of digit index and its SEG pattern take effect on the same edge, with no glitch between digits.

Decomposition:
- Package freq_display_pkg holds:
  - State enum: IDLE, SHIFT, DONE.
  - Constants SEG_BLANK, SEG_DASH, SEG_DIGIT[0..9].
  - Function returning the scratch width from IN_W.
- One natural sub-module: seg7_decode. Combinational; 4-bit BCD plus blank/dash controls in, 7-bit active-low SEG out. The top level instantiates it once on the muxed digit.

Test Plan (REFRESH_DIV=4, IN_W=16, DIGITS=4):
1. RESET=0 for 2 cycles, then 1 -> BUSY=0, AN=1110, SEG=1000000. After 4 cycles AN=1101 and SEG=1111111 (blank).
2. LOAD with VALUE=1234 -> BUSY high for exactly 17 cycles. Display then scans AN0..AN3 showing 0011001, 0110000, 0100100, 1111001.
3. LOAD with VALUE=7 -> AN0 shows 1111000; AN1, AN2, AN3 show 1111111.
4. LOAD with VALUE=10000 -> all four digits show 0111111. Next, LOAD with VALUE=0 -> overflow clears; AN0 shows 1000000 and the others are blank.
5. LOAD with VALUE=1234, then LOAD with VALUE=5678 on BUSY cycle 5, and another LOAD in the DONE cycle -> both ignored; display shows 1234. A later LOAD with VALUE=5678 after BUSY=0 is accepted.
6. Display 42, then LOAD with VALUE=9999 and pull RESET low on BUSY cycle 8 -> BUSY=0 and display "0" next cycle. After release, LOAD with VALUE=9999 -> all digits 0010000.

Source files
------------

// File: rtl/freq_display_pkg.sv
// freq_display_pkg: shared FSM states, segment patterns and sizing helper
package freq_display_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic int scratch_w(input int in_w);
        return 4 * ((in_w + 2) / 3);
    endfunction

endpackage

// File: rtl/freq_display_seg7_decode.sv
// seg7_decode: BCD nibble to active-low {g,f,e,d,c,b,a} with blank/dash overrides
module seg7_decode
    import freq_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    input  logic       dash_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (dash_i)
            seg_o = SEG_DASH;
        else if (!blank_i && bcd_i <= 4'd9)
            seg_o = SEG_DIGIT[bcd_i];
    end

endmodule

// File: rtl/freq_display.sv
// freq_display: sequential binary-to-BCD conversion and multiplexed 7-segment drive
module freq_display
    import freq_display_pkg::*;
#(
    parameter int IN_W        = 16,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [IN_W-1:0]   value_i,
    input  logic              load_i,
    output logic              busy_o,
    output logic [6:0]        seg_o,
    output logic [DIGITS-1:0] an_o
);

    localparam int SW = scratch_w(IN_W);
    localparam int DW = 4 * DIGITS;
    localparam int CW = $clog2(IN_W + 1);
    localparam int RW = $clog2(REFRESH_DIV + 1);
    localparam int IW = $clog2(DIGITS + 1);

    state_e            state_q, state_d;
    logic [IN_W-1:0]   shift_q, shift_d;
    logic [SW-1:0]     scratch_q, scratch_d, adj;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     disp_q, disp_d;
    logic              ovf_q, ovf_d;
    logic [RW-1:0]     ref_q, ref_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [SW+DW-1:0]  ext;
    logic [3:0]        digit;
    logic              blank, wrap;

    // Zero-extension lets the overflow test work even when scratch is no wider than the display
    assign ext = {{DW{1'b0}}, scratch_q};

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        disp_d    = disp_q;
        ovf_d     = ovf_q;
        adj       = scratch_q;
        for (int i = 0; i < SW / 4; i++)
            if (scratch_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        case (state_q)
            IDLE: if (load_i) begin
                state_d   = SHIFT;
                shift_d   = value_i;
                scratch_d = '0;
                cnt_d     = CW'(IN_W);
            end
            SHIFT: begin
                scratch_d = {adj[SW-2:0], shift_q[IN_W-1]};
                shift_d   = shift_q << 1;
                cnt_d     = cnt_q - CW'(1);
                state_d   = (cnt_q == CW'(1)) ? DONE : SHIFT;
            end
            DONE: begin
                disp_d  = ext[DW-1:0];
                ovf_d   = |ext[SW+DW-1:DW];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Decode from next-state values so SEG always matches the AN it is registered with
    always_comb begin
        wrap  = ref_q == RW'(REFRESH_DIV - 1);
        ref_d = wrap ? '0 : ref_q + RW'(1);
        idx_d = wrap ? ((idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1)) : idx_q;
        digit = disp_d[4*idx_d +: 4];
        blank = (idx_d != '0) && ((disp_d >> (4 * idx_d)) == '0);
        an_d  = ~(DIGITS'(1) << idx_d);
    end

    seg7_decode u_dec (
        .bcd_i   (digit),
        .blank_i (blank),
        .dash_i  (ovf_d),
        .seg_o   (seg_d)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            disp_q    <= '0;
            ovf_q     <= 1'b0;
            ref_q     <= '0;
            idx_q     <= '0;
            seg_q     <= SEG_DIGIT[0];
            an_q      <= ~DIGITS'(1);
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            disp_q    <= disp_d;
            ovf_q     <= ovf_d;
            ref_q     <= ref_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign busy_o = state_q != IDLE;
    assign seg_o  = seg_q;
    assign an_o   = an_q;

endmodule
